mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-ported synchronous memory (1-cycle read latency) between the pipelined core's
//  instruction-fetch port (I) and data port (D). Grants one request per cycle, data-first with a
//  starvation guard for fetch. Returns read data tagged to its owner. Core uses ~gnt to drive stalls.
// PARAMETERS
//  AW          32  address width (byte address, passed through unchanged)
//  DW          32  data width
//  STARVE_MAX  4   consecutive cycles an I request may lose before it is forced to win (>=1)
// PORTS
//  clk        in   1   rising-edge clock
//  reset      in   1   asynchronous, active-low reset
//  i_req      in   1   fetch request (read only), held until i_gnt
//  i_addr     in   AW  fetch address
//  i_gnt      out  1   fetch request accepted this cycle
//  i_rvalid   out  1   i_rdata valid (cycle after i_gnt)
//  i_rdata    out  DW  fetched instruction
//  d_req      in   1   data request, held until d_gnt
//  d_we       in   1   1 = store, 0 = load
//  d_addr     in   AW  data address
//  d_wdata    in   DW  store data
//  d_gnt      out  1   data request accepted this cycle
//  d_rvalid   out  1   d_rdata valid (cycle after a load grant; never for stores)
//  d_rdata    out  DW  load data
//  mem_en     out  1   memory access this cycle
//  mem_we     out  1   memory write enable
//  mem_addr   out  AW  memory address
//  mem_wdata  out  DW  memory write data
//  mem_rdata  in   DW  memory read data, valid cycle after mem_en && !mem_we
// BEHAVIOUR
//  - Reset (reset==0, async): starve_cnt=0, rsp_owner=NONE; every output 0.
//  - Grant logic combinational from req + registered state; memory outputs are combinational copies
//    of the winning request (mem_en = i_gnt|d_gnt; mem_we = d_gnt&d_we). At most one gnt per cycle.
//  - Priority: D wins when both request, unless starve_cnt==STARVE_MAX, in which case I wins.
//  - starve_cnt: +1 each cycle i_req && !i_gnt; cleared on i_gnt or !i_req; saturates at STARVE_MAX.
//  - Response tracking: rsp_owner register {NONE,IFETCH,DLOAD} loaded each cycle: IFETCH on i_gnt,
//    DLOAD on d_gnt&&!d_we, else NONE. Next cycle: i_rvalid=(owner==IFETCH), d_rvalid=(owner==DLOAD);
//    i_rdata/d_rdata = mem_rdata when respective rvalid, else 0.
//  - Latency: request granted in cycle N -> rvalid in N+1. Back-to-back grants allowed every cycle;
//    a grant in N+1 overlaps response of N (fully pipelined, one response outstanding max).
//  - Stores: single-cycle, no rvalid; rsp_owner=NONE after a store grant.
//  - Idle (no req): all gnt 0, mem_en 0, starve_cnt cleared.
//  - Request withdrawn before gnt: allowed; counter clears, nothing issued.
//  - Reset mid-operation: pending response discarded; no rvalid in first cycle after release.
//  - Address/data never modified; widths AW/DW throughout, no arithmetic beyond counter
//    ($clog2(STARVE_MAX+1) bits, no wrap).
// STRUCTURE
//  - Shared package: rsp_owner encoding (NONE=2'd0, IFETCH=2'd1, DLOAD=2'd2) and default STARVE_MAX.
//  - One sub-module natural: arb_starve_ctr (saturating counter + force flag). Rest is flat.
// TESTING
//  1. Reset asserted with i_req=d_req=1 -> all outputs 0; after release first cycle: d_gnt=1, i_gnt=0.
//  2. i_req only, i_addr=0x100 -> i_gnt same cycle, mem_addr=0x100, mem_en=1; next cycle i_rvalid=1,
//     i_rdata=mem_rdata (e.g. 0x00500093).
//  3. Both requesting continuously, STARVE_MAX=4 -> d_gnt cycles 1-4, i_gnt cycle 5, d_gnt cycle 6.
//  4. d_req store d_addr=0x2000 d_wdata=0xDEADBEEF -> mem_we=1, mem_wdata=0xDEADBEEF, no d_rvalid.
//  5. Alternating I fetch / D load each cycle -> one rvalid per cycle, owner matches previous grant.
//  6. Load granted, reset pulsed low next cycle -> no d_rvalid observed; counter 0 after release.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the I/D memory port arbiter: response-owner encoding and default starvation limit.
package mem_port_arbiter_pkg;

  localparam int STARVE_MAX_DEF = 4;

  typedef enum logic [1:0] {
    OWN_NONE   = 2'd0,
    OWN_IFETCH = 2'd1,
    OWN_DLOAD  = 2'd2
  } rsp_owner_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Core fetch/data ports plus the shared single-ported memory, bundled for the arbiter.
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_gnt;
  logic          i_rvalid;
  logic [DW-1:0] i_rdata;

  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt;
  logic          d_rvalid;
  logic [DW-1:0] d_rdata;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  // Core and memory model side.
  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );

  // Arbiter side.
  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter_arb_starve_ctr.sv
// Counts consecutive cycles a fetch request loses arbitration; force_o flips priority to fetch at the limit.
module arb_starve_ctr
  import mem_port_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic i_req_i,
  input  logic i_gnt_i,
  output logic force_o
);

  localparam int            CW      = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_MAX);

  logic [CW-1:0] cnt_q, cnt_d;

  // Any cycle without a losing fetch request (granted or withdrawn) restarts the count.
  always_comb begin
    cnt_d = '0;
    if (i_req_i && !i_gnt_i) begin
      cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign force_o = (cnt_q == CNT_MAX);

endmodule

// File: rtl/mem_port_arbiter.sv
// Grants one of fetch/data to the shared memory each cycle (data first, fetch forced after STARVE_MAX losses);
// read data returns tagged one cycle after its grant, no backpressure beyond withholding gnt.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic                clk,
  input  logic                reset,
  mem_port_arbiter_if.slave   bus
);

  logic       force_i;
  logic       i_gnt;
  logic       d_gnt;
  rsp_owner_e owner_q, owner_d;

  // Gated by reset so every output is quiet while reset is held, even with requests pending.
  assign i_gnt = reset && bus.i_req && (!bus.d_req || force_i);
  assign d_gnt = reset && bus.d_req && !i_gnt;

  arb_starve_ctr #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve (
    .clk     (clk),
    .reset   (reset),
    .i_req_i (bus.i_req),
    .i_gnt_i (i_gnt),
    .force_o (force_i)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner_q <= OWN_NONE;
    end else begin
      owner_q <= owner_d;
    end
  end

  always_comb begin
    owner_d = OWN_NONE;
    if (i_gnt) begin
      owner_d = OWN_IFETCH;
    end else if (d_gnt && !bus.d_we) begin
      owner_d = OWN_DLOAD;
    end
  end

  always_comb begin
    bus.i_gnt     = i_gnt;
    bus.d_gnt     = d_gnt;
    bus.mem_en    = i_gnt || d_gnt;
    bus.mem_we    = d_gnt && bus.d_we;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (d_gnt) begin
      bus.mem_addr  = bus.d_addr;
      bus.mem_wdata = bus.d_wdata;
    end else if (i_gnt) begin
      bus.mem_addr  = bus.i_addr;
    end
    bus.i_rvalid = (owner_q == OWN_IFETCH);
    bus.d_rvalid = (owner_q == OWN_DLOAD);
    bus.i_rdata  = bus.i_rvalid ? bus.mem_rdata : '0;
    bus.d_rdata  = bus.d_rvalid ? bus.mem_rdata : '0;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: reset, priority/starvation, load/store/fetch responses, mid-op reset.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  mem_port_arbiter_if #(.AW(32), .DW(32)) bus ();

  mem_port_arbiter #(
    .AW         (32),
    .DW         (32),
    .STARVE_MAX (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset         = 1'b0;
    bus.i_req     = 1'b1;
    bus.d_req     = 1'b1;
    bus.d_we      = 1'b0;
    bus.i_addr    = 32'h100;
    bus.d_addr    = 32'h40;
    bus.d_wdata   = 32'h0;
    bus.mem_rdata = 32'hA5A5_0001;

    // Reset held with both requesting: everything quiet.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_i_gnt",     bus.i_gnt, 0);
    chk("rst_d_gnt",     bus.d_gnt, 0);
    chk("rst_mem_en",    bus.mem_en, 0);
    chk("rst_mem_we",    bus.mem_we, 0);
    chk("rst_mem_addr",  bus.mem_addr, 0);
    chk("rst_mem_wdata", bus.mem_wdata, 0);
    chk("rst_i_rvalid",  bus.i_rvalid, 0);
    chk("rst_d_rvalid",  bus.d_rvalid, 0);
    chk("rst_i_rdata",   bus.i_rdata, 0);
    chk("rst_d_rdata",   bus.d_rdata, 0);

    // Release: data wins cycles 1-4, fetch forced on 5, data again on 6.
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("c1_d_gnt",    bus.d_gnt, 1);
    chk("c1_i_gnt",    bus.i_gnt, 0);
    chk("c1_mem_addr", bus.mem_addr, 32'h40);
    chk("c1_mem_en",   bus.mem_en, 1);
    chk("c1_mem_we",   bus.mem_we, 0);
    chk("c1_d_rvalid", bus.d_rvalid, 0);
    for (int k = 2; k <= 4; k++) begin
      cyc();
      bus.mem_rdata = 32'h1000 + k;
      @(negedge clk);
      chk("cN_d_gnt",    bus.d_gnt, 1);
      chk("cN_i_gnt",    bus.i_gnt, 0);
      chk("cN_d_rvalid", bus.d_rvalid, 1);
      chk("cN_d_rdata",  bus.d_rdata, 32'h1000 + k);
    end
    cyc();
    @(negedge clk);
    chk("c5_i_gnt",    bus.i_gnt, 1);
    chk("c5_d_gnt",    bus.d_gnt, 0);
    chk("c5_mem_addr", bus.mem_addr, 32'h100);
    chk("c5_d_rvalid", bus.d_rvalid, 1);
    cyc();
    bus.mem_rdata = 32'h00C0_FFEE;
    @(negedge clk);
    chk("c6_d_gnt",    bus.d_gnt, 1);
    chk("c6_i_rvalid", bus.i_rvalid, 1);
    chk("c6_i_rdata",  bus.i_rdata, 32'h00C0_FFEE);
    chk("c6_d_rvalid", bus.d_rvalid, 0);
    chk("c6_d_rdata",  bus.d_rdata, 0);

    // Fetch alone at 0x100, then instruction returns next cycle.
    cyc();
    bus.d_req = 1'b0;
    @(negedge clk);
    chk("f_i_gnt",    bus.i_gnt, 1);
    chk("f_d_gnt",    bus.d_gnt, 0);
    chk("f_mem_en",   bus.mem_en, 1);
    chk("f_mem_addr", bus.mem_addr, 32'h100);
    chk("f_d_rvalid", bus.d_rvalid, 1);
    cyc();
    bus.i_req     = 1'b0;
    bus.mem_rdata = 32'h0050_0093;
    @(negedge clk);
    chk("f_i_rvalid", bus.i_rvalid, 1);
    chk("f_i_rdata",  bus.i_rdata, 32'h0050_0093);
    chk("idle_i_gnt", bus.i_gnt, 0);
    chk("idle_mem_en", bus.mem_en, 0);

    // Store: written through, never produces a response.
    cyc();
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b1;
    bus.d_addr  = 32'h2000;
    bus.d_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("st_d_gnt",     bus.d_gnt, 1);
    chk("st_mem_we",    bus.mem_we, 1);
    chk("st_mem_addr",  bus.mem_addr, 32'h2000);
    chk("st_mem_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
    chk("st_i_rvalid",  bus.i_rvalid, 0);
    cyc();
    bus.d_req = 1'b0;
    bus.d_we  = 1'b0;
    @(negedge clk);
    chk("st_d_rvalid", bus.d_rvalid, 0);
    chk("st_i_rvalid2", bus.i_rvalid, 0);
    chk("st_mem_en",   bus.mem_en, 0);

    // Alternate fetch / load every cycle; each response belongs to the previous grant.
    for (int k = 0; k < 6; k++) begin
      cyc();
      bus.i_req     = (k % 2 == 0);
      bus.d_req     = (k % 2 != 0);
      bus.i_addr    = 32'h200 + 32'(4 * k);
      bus.d_addr    = 32'h3000 + 32'(4 * k);
      bus.mem_rdata = 32'hB000 + 32'(k);
      @(negedge clk);
      if (k % 2 == 0) begin
        chk("alt_i_gnt",    bus.i_gnt, 1);
        chk("alt_i_addr",   bus.mem_addr, 32'h200 + 32'(4 * k));
      end else begin
        chk("alt_d_gnt",    bus.d_gnt, 1);
        chk("alt_d_addr",   bus.mem_addr, 32'h3000 + 32'(4 * k));
      end
      if (k == 0) begin
        chk("alt0_i_rvalid", bus.i_rvalid, 0);
        chk("alt0_d_rvalid", bus.d_rvalid, 0);
      end else if (k % 2 == 1) begin
        chk("alt_i_rvalid", bus.i_rvalid, 1);
        chk("alt_i_rdata",  bus.i_rdata, 32'hB000 + 32'(k));
        chk("alt_d_rv0",    bus.d_rvalid, 0);
      end else begin
        chk("alt_d_rvalid", bus.d_rvalid, 1);
        chk("alt_d_rdata",  bus.d_rdata, 32'hB000 + 32'(k));
        chk("alt_i_rv0",    bus.i_rvalid, 0);
      end
    end

    // Fetch loses twice, withdraws, re-requests: count starts over, four more losses.
    cyc();
    bus.i_req = 1'b1;
    bus.d_req = 1'b1;
    @(negedge clk);
    chk("wd1_d_gnt", bus.d_gnt, 1);
    cyc();
    @(negedge clk);
    chk("wd2_d_gnt", bus.d_gnt, 1);
    cyc();
    bus.i_req = 1'b0;
    @(negedge clk);
    chk("wd3_d_gnt", bus.d_gnt, 1);
    for (int k = 1; k <= 4; k++) begin
      cyc();
      bus.i_req = 1'b1;
      @(negedge clk);
      chk("wd_lose_d_gnt", bus.d_gnt, 1);
      chk("wd_lose_i_gnt", bus.i_gnt, 0);
    end
    cyc();
    @(negedge clk);
    chk("wd_force_i_gnt", bus.i_gnt, 1);

    // Load granted, then reset pulsed: the response is dropped and the count restarts.
    cyc();
    bus.i_req = 1'b0;
    bus.d_req = 1'b1;
    bus.d_we  = 1'b0;
    @(negedge clk);
    chk("mr_d_gnt", bus.d_gnt, 1);
    cyc();
    reset = 1'b0;
    #1;
    chk("mr_d_rvalid_rst", bus.d_rvalid, 0);
    chk("mr_d_gnt_rst",    bus.d_gnt, 0);
    chk("mr_mem_en_rst",   bus.mem_en, 0);
    cyc();
    reset     = 1'b1;
    bus.i_req = 1'b1;
    @(negedge clk);
    chk("mr_post_d_rvalid", bus.d_rvalid, 0);
    chk("mr_post_d_gnt",    bus.d_gnt, 1);
    for (int k = 2; k <= 4; k++) begin
      cyc();
      @(negedge clk);
      chk("mr_lose_d_gnt", bus.d_gnt, 1);
    end
    cyc();
    @(negedge clk);
    chk("mr_force_i_gnt", bus.i_gnt, 1);

    cyc();
    bus.i_req = 1'b0;
    bus.d_req = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
